qpi_psram_responder: RTL and testbench

//  Device-side model of one 4-bit PSRAM die on the shared QPI bus, driven by our PSRAM controller.

---
 rtl/psram_pkg.sv | 25 ++
 rtl/qpi_psram_responder_if.sv | 34 +++
 rtl/qpi_sync_edge.sv | 45 ++++
 rtl/qpi_psram_responder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_qpi_psram_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared command codes, FSM states and defaults for the QPI PSRAM responder
// Purpose: constants and types used by qpi_psram_responder and its testbench.
// Ports: none (package).
package psram_pkg;

    localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
    localparam logic [7:0] CMD_QREAD     = 8'hEB;
    localparam logic [7:0] CMD_QWRITE    = 8'h38;
    localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;

    // SCLK rises between the last address nibble and the first read nibble
    localparam int READ_WAIT_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_QPI_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } resp_state_t;

endpackage

// File: rtl/qpi_psram_responder_if.sv
// rtl/qpi_psram_responder_if.sv - one nibble lane of the shared QPI PSRAM bus
// Purpose: groups the PSRAM pins seen by one die.
// Signals:
//   psram_csn  chip select, active low (controller -> die)
//   psram_sclk serial clock (controller -> die)
//   sio_in     SIO[3:0] as seen on the bus (controller -> die)
//   sio_out    nibble driven back during read data (die -> controller)
//   sio_oe     1 = die drives sio_out onto the bus
// Modports: master = controller side, slave = die side.
interface qpi_psram_responder_if;

    logic       psram_csn;
    logic       psram_sclk;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       sio_oe;

    modport master (
        output psram_csn,
        output psram_sclk,
        output sio_in,
        input  sio_out,
        input  sio_oe
    );

    modport slave (
        input  psram_csn,
        input  psram_sclk,
        input  sio_in,
        output sio_out,
        output sio_oe
    );

endinterface

// File: rtl/qpi_sync_edge.sv
// rtl/qpi_sync_edge.sv - multi-flop synchronizer with one-clock rise/fall pulses
// Purpose: brings an asynchronous pin into i_clk and flags its edges.
// Ports:
//   i_clk    sampling clock
//   i_rst    asynchronous, active-high reset
//   i_d      asynchronous input
//   o_level  synchronized level
//   o_rise   one-clock pulse when o_level goes 0 -> 1
//   o_fall   one-clock pulse when o_level goes 1 -> 0
// RST_VAL lets CSn reset high so no false select is seen leaving reset.
module qpi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~prev_q;
    assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/qpi_psram_responder.sv
// rtl/qpi_psram_responder.sv - device-side model of one 4-bit PSRAM die on the QPI bus
// Purpose: oversamples CSn/SCLK/SIO, decodes SPI 35h and QPI EBh/38h/F5h and
//   serves reads/writes through a byte memory port.
// Ports:
//   i_clk        oversampling clock (SCLK <= i_clk/4)
//   i_rst        asynchronous, active-high reset
//   bus          qpi_psram_responder_if.slave: csn, sclk, sio in/out, sio_oe
//   o_qpi_mode   1 = QPI mode entered
//   o_mem_addr   byte address for the memory port
//   o_mem_re     one-clock read strobe; i_mem_rdata valid the clock after
//   i_mem_rdata  read data
//   o_mem_we     one-clock write strobe
//   o_mem_wdata  write data, valid with o_mem_we
// Build option: QPI_RESP_BURST_EN enables address auto-increment and
//   multi-byte transfers until CSn rises; otherwise one byte per select.
module qpi_psram_responder
    import psram_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int READ_WAIT   = READ_WAIT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    qpi_psram_responder_if.slave      bus,
    output logic                      o_qpi_mode,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_re,
    input  logic [7:0]                i_mem_rdata,
    output logic                      o_mem_we,
    output logic [7:0]                o_mem_wdata
);

`ifdef QPI_RESP_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT);

    logic csn_level, csn_rise, csn_fall;
    logic sclk_level, sclk_rise, sclk_fall;

    qpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (bus.psram_csn),
        .o_level(csn_level),
        .o_rise (csn_rise),
        .o_fall (csn_fall)
    );

    qpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (bus.psram_sclk),
        .o_level(sclk_level),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    // SIO goes through the same depth as SCLK so it lines up with sclk_rise
    logic [SYNC_STAGES-1:0][3:0] sio_sync_q, sio_sync_d;
    logic [3:0]                  sio;

    resp_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_read_q, is_read_d;
    logic              enter_q, enter_d;      // QPI entry waits for CSn rise
    logic              exit_q, exit_d;        // QPI exit waits for CSn rise
    logic              qpi_q, qpi_d;
    logic [3:0]        sio_out_q, sio_out_d;
    logic              sio_oe_q, sio_oe_d;
    logic [3:0]        lo_q, lo_d;            // low nibble held while the next byte is fetched
    logic              phase_q, phase_d;      // 1 = high nibble is on the bus
    logic              mem_re_q, mem_re_d;
    logic              re_dly_q, re_dly_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        wdata_q, wdata_d;

    assign sio = sio_sync_q[SYNC_STAGES-1];

    always_comb begin
        sio_sync_d[0] = bus.sio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sio_sync_d[i] = sio_sync_q[i-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        enter_d   = enter_q;
        exit_d    = exit_q;
        qpi_d     = qpi_q;
        sio_out_d = sio_out_q;
        sio_oe_d  = sio_oe_q;
        lo_d      = lo_q;
        phase_d   = phase_q;
        wdata_d   = wdata_q;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        re_dly_d  = mem_re_q;
        // memory answers the clock after the strobe
        rdata_d   = re_dly_q ? i_mem_rdata : rdata_q;

        // advance only once the written byte has been presented at the old address
        if (BURST_EN && mem_we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (csn_level) begin
            state_d  = ST_IDLE;
            sio_oe_d = 1'b0;
            cnt_d    = 4'd0;
            if (enter_q) qpi_d = 1'b1;
            if (exit_q)  qpi_d = 1'b0;
            enter_d  = 1'b0;
            exit_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state_d = qpi_q ? ST_QPI_CMD : ST_SPI_CMD;
                        cnt_d   = 4'd0;
                    end
                end
                ST_SPI_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[6:0], sio[0]};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            enter_d = (cmd_d == CMD_ENTER_QPI);
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_QPI_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[3:0], sio};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd1) begin
                            cnt_d = 4'd0;
                            case (cmd_d)
                                CMD_QREAD: begin
                                    is_read_d = 1'b1;
                                    state_d   = ST_ADDR;
                                end
                                CMD_QWRITE: begin
                                    is_read_d = 1'b0;
                                    state_d   = ST_ADDR;
                                end
                                CMD_EXIT_QPI: begin
                                    exit_d  = 1'b1;
                                    state_d = ST_IGNORE;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d = ADDR_W'({addr_q, sio});
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd5) begin
                            cnt_d = 4'd0;
                            if (is_read_q) begin
                                mem_re_d = 1'b1;
                                state_d  = ST_WAIT;
                            end else begin
                                state_d  = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (sclk_rise && cnt_q != WAIT_LAST) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (sclk_fall && cnt_q == WAIT_LAST) begin
                        sio_oe_d  = 1'b1;
                        sio_out_d = rdata_q[7:4];
                        lo_d      = rdata_q[3:0];
                        phase_d   = 1'b1;
                        state_d   = ST_RDATA;
                        if (BURST_EN) begin
                            addr_d   = addr_q + ADDR_W'(1);
                            mem_re_d = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        if (phase_q) begin
                            sio_out_d = lo_q;
                            phase_d   = 1'b0;
                        end else if (BURST_EN) begin
                            sio_out_d = rdata_q[7:4];
                            lo_d      = rdata_q[3:0];
                            phase_d   = 1'b1;
                            addr_d    = addr_q + ADDR_W'(1);
                            mem_re_d  = 1'b1;
                        end else begin
                            sio_oe_d = 1'b0;
                            state_d  = ST_IGNORE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        if (cnt_q == 4'd0) begin
                            wdata_d[7:4] = sio;
                            cnt_d        = 4'd1;
                        end else begin
                            wdata_d[3:0] = sio;
                            cnt_d        = 4'd0;
                            mem_we_d     = 1'b1;
                            if (!BURST_EN) state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    sio_oe_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sio_sync_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            cmd_q      <= 8'd0;
            addr_q     <= '0;
            is_read_q  <= 1'b0;
            enter_q    <= 1'b0;
            exit_q     <= 1'b0;
            qpi_q      <= 1'b0;
            sio_out_q  <= 4'd0;
            sio_oe_q   <= 1'b0;
            lo_q       <= 4'd0;
            phase_q    <= 1'b0;
            mem_re_q   <= 1'b0;
            re_dly_q   <= 1'b0;
            rdata_q    <= 8'd0;
            mem_we_q   <= 1'b0;
            wdata_q    <= 8'd0;
        end else begin
            sio_sync_q <= sio_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            enter_q    <= enter_d;
            exit_q     <= exit_d;
            qpi_q      <= qpi_d;
            sio_out_q  <= sio_out_d;
            sio_oe_q   <= sio_oe_d;
            lo_q       <= lo_d;
            phase_q    <= phase_d;
            mem_re_q   <= mem_re_d;
            re_dly_q   <= re_dly_d;
            rdata_q    <= rdata_d;
            mem_we_q   <= mem_we_d;
            wdata_q    <= wdata_d;
        end
    end

    // SCLK level and CSn rise are carried for completeness of the edge detectors
    logic unused_ok;
    assign unused_ok = sclk_level ^ csn_rise;

    assign bus.sio_out  = sio_out_q;
    assign bus.sio_oe   = sio_oe_q;
    assign o_qpi_mode   = qpi_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_re     = mem_re_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_qpi_psram_responder.sv
// tb/tb_qpi_psram_responder.sv - self-checking bench for qpi_psram_responder
module tb_qpi_psram_responder;
    import psram_pkg::*;

    localparam int HALF = 6;
    localparam int RW   = READ_WAIT_DEF;
`ifdef QPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        qpi_mode;
    logic [23:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    qpi_psram_responder_if bus_if();

    qpi_psram_responder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus_if),
        .o_qpi_mode (qpi_mode),
        .o_mem_addr (mem_addr),
        .o_mem_re   (mem_re),
        .i_mem_rdata(mem_rdata),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata)
    );

    logic [7:0] mem [int];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  data;
    } vec_t;

    wr_t         exp_wr[$];
    logic [23:0] exp_re[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every memory strobe must match the oldest expectation
    always @(negedge clk) begin
        wr_t         w;
        logic [23:0] ra;
        if (!rst) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("unexpected_we", 32'(mem_we), 32'd0);
                else begin
                    w = exp_wr.pop_front();
                    chk("we_addr", 32'(mem_addr), 32'(w.addr));
                    chk("we_data", 32'(mem_wdata), 32'(w.data));
                end
            end
            if (mem_re) begin
                if (exp_re.size() == 0) chk("unexpected_re", 32'(mem_re), 32'd0);
                else begin
                    ra = exp_re.pop_front();
                    chk("re_addr", 32'(mem_addr), 32'(ra));
                end
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_pulse();
        bus_if.psram_sclk = 1'b1;
        clk_n(HALF);
        bus_if.psram_sclk = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] nib);
        bus_if.sio_in = nib;
        clk_n(HALF);
        sclk_pulse();
    endtask

    task automatic cs_lo();
        bus_if.psram_csn = 1'b0;
        clk_n(HALF);
    endtask

    task automatic cs_hi();
        clk_n(HALF);
        bus_if.psram_csn = 1'b1;
        clk_n(HALF);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        cyc(b[7:4]);
        cyc(b[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int nbytes);
        wr_t w;
        w.addr = a; w.data = d0;
        exp_wr.push_back(w);
        if (nbytes == 2 && BURST) begin
            w.addr = a + 24'd1; w.data = d1;
            exp_wr.push_back(w);
        end
        cs_lo();
        qpi_byte(CMD_QWRITE);
        qpi_addr(a);
        qpi_byte(d0);
        if (nbytes == 2) qpi_byte(d1);
        cs_hi();
    endtask

    // nibs holds up to four expected nibbles, first in [15:12]; abort raises CSn while oe=1
    task automatic qpi_read(input logic [23:0] a, input logic [15:0] nibs, input int nnib, input bit abort);
        int nre;
        int falls;
        falls = abort ? nnib - 1 : nnib;
        nre   = BURST ? 2 + falls / 2 : 1;
        for (int j = 0; j < nre; j++) exp_re.push_back(a + 24'(j));
        cs_lo();
        qpi_byte(CMD_QREAD);
        qpi_addr(a);
        for (int w = 0; w < RW; w++) begin
            bus_if.sio_in = 4'h0;
            clk_n(HALF);
            chk("wait_oe", 32'(bus_if.sio_oe), 32'd0);
            sclk_pulse();
        end
        for (int k = 0; k < nnib; k++) begin
            if (k > 0) sclk_pulse();
            clk_n(HALF);
            chk("rd_oe", 32'(bus_if.sio_oe), 32'd1);
            chk("rd_nib", 32'(bus_if.sio_out), 32'(nibs[15 - 4*k -: 4]));
        end
        if (!abort) begin
            sclk_pulse();
            clk_n(HALF);
            chk("end_oe", 32'(bus_if.sio_oe), 32'(BURST));
        end
        bus_if.psram_csn = 1'b1;
        clk_n(3);
        chk("cs_oe_drop", 32'(bus_if.sio_oe), 32'd0);
        chk("cs_state", 32'(dut.state_q), 32'(ST_IDLE));
        clk_n(HALF);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 24'h012345, 8'hA5};
        vecs[1] = '{1'b1, 24'h000010, 8'h3C};
        vecs[2] = '{1'b0, 24'h000010, 8'h3C};
        vecs[3] = '{1'b1, 24'hABCDEF, 8'h5A};
        vecs[4] = '{1'b0, 24'h012345, 8'hA5};
        vecs[5] = '{1'b0, 24'hABCDEF, 8'h5A};
        vecs[6] = '{1'b1, 24'h000000, 8'hFF};
        vecs[7] = '{1'b0, 24'h000000, 8'hFF};

        bus_if.psram_csn  = 1'b1;
        bus_if.psram_sclk = 1'b0;
        bus_if.sio_in     = 4'h0;
        clk_n(3);
        rst = 1'b0;
        clk_n(2);

        chk("rst_oe", 32'(bus_if.sio_oe), 32'd0);
        chk("rst_sio", 32'(bus_if.sio_out), 32'd0);
        chk("rst_qpi", 32'(qpi_mode), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // enter QPI via SPI 35h; mode changes only on CSn rise
        cs_lo();
        spi_byte(CMD_ENTER_QPI);
        chk("qpi_before_csn", 32'(qpi_mode), 32'd0);
        cs_hi();
        chk("qpi_entered", 32'(qpi_mode), 32'd1);
        cs_lo();
        qpi_byte(CMD_EXIT_QPI);
        cs_hi();
        chk("qpi_exited", 32'(qpi_mode), 32'd0);
        cs_lo();
        spi_byte(CMD_ENTER_QPI);
        cs_hi();
        chk("qpi_reentered", 32'(qpi_mode), 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) qpi_write(vecs[i].addr, vecs[i].data, 8'h00, 1);
            else qpi_read(vecs[i].addr, {vecs[i].data, 8'h00}, 2, 1'b0);
        end

        // CSn raised after the first write nibble: nothing written
        cs_lo();
        qpi_byte(CMD_QWRITE);
        qpi_addr(24'h000777);
        cyc(4'hA);
        bus_if.psram_csn = 1'b1;
        clk_n(3);
        chk("abort_wr_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("abort_wr_oe", 32'(bus_if.sio_oe), 32'd0);
        clk_n(HALF);

        // CSn raised while the high read nibble is on the bus
        qpi_read(24'h000010, 16'h3000, 1, 1'b1);

        // unknown QPI command is ignored until CSn rises
        cs_lo();
        qpi_byte(8'h9F);
        for (int i = 0; i < 8; i++) begin
            cyc(4'($urandom_range(0, 15)));
            chk("ign_oe", 32'(bus_if.sio_oe), 32'd0);
        end
        chk("ign_state", 32'(dut.state_q), 32'(ST_IGNORE));
        cs_hi();
        chk("ign_qpi_kept", 32'(qpi_mode), 32'd1);

        // burst read across the top of the address space, and a two-byte write
        mem[24'hFFFFFF] = 8'h96;
        if (BURST) qpi_read(24'hFFFFFF, 16'h96FF, 4, 1'b0);
        else qpi_read(24'hFFFFFF, 16'h9600, 2, 1'b0);
        qpi_write(24'h000100, 8'h12, 8'h34, 2);

        clk_n(10);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("re_queue_empty", 32'(exp_re.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
